// File: rtl/text_buffer.sv
// Character-cell text memory for the VGA text path: stores an 80x30 grid of codes,
// owns the cursor and the full-screen / single-row clear engines.
module text_buffer #(
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int CHAR_W_BITS = 3,
  parameter int CHAR_H_BITS = 4,
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 10
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic [7:0]             char_in,
  input  logic                   char_valid_in,
  output logic                   ready_out,
  input  logic [WIDTH_BITS-1:0]  pixel_x_in,
  input  logic [HEIGHT_BITS-1:0] pixel_y_in,
  output logic [7:0]             char_code_out,
  output logic [6:0]             cursor_col_out,
  output logic [4:0]             cursor_row_out,
  output logic [1:0]             dbg_state_out
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TCOL_W = WIDTH_BITS - CHAR_W_BITS;
  localparam int TROW_W = HEIGHT_BITS - CHAR_H_BITS;

  localparam logic [7:0]        BLANK         = 8'h20;
  localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_CELL = ADDR_W'(COLS - 1);
  localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW      = 5'(ROWS - 1);

  // Write port handshake: a byte on char_in is consumed on the rising edge where
  // char_valid_in && ready_out; the source holds char_in/char_valid_in until then.
  typedef enum logic [1:0] {CLEAR_ALL = 2'd0, IDLE = 2'd1, CLEAR_ROW = 2'd2} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [6:0]        col_q;
  logic [4:0]        row_q;
  logic              ready_q;
  logic [7:0]        code_q;

  logic [7:0] mem [DEPTH];

  logic [TCOL_W-1:0] tile_col;
  logic [TROW_W-1:0] tile_row;
  logic              in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] row_base;
  logic [4:0]        next_row;
  logic              accept;
  logic              printable;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              unused_pix_bits;

  assign tile_col        = pixel_x_in[WIDTH_BITS-1:CHAR_W_BITS];
  assign tile_row        = pixel_y_in[HEIGHT_BITS-1:CHAR_H_BITS];
  assign unused_pix_bits = ^{pixel_x_in[CHAR_W_BITS-1:0], pixel_y_in[CHAR_H_BITS-1:0]};
  assign in_range        = (tile_col < TCOL_W'(COLS)) && (tile_row < TROW_W'(ROWS));
  assign rd_addr         = ADDR_W'(tile_row) * ADDR_W'(COLS) + ADDR_W'(tile_col);
  assign row_base        = ADDR_W'(row_q) * ADDR_W'(COLS);
  assign next_row        = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign accept          = char_valid_in && ready_q;
  assign printable       = (char_in >= 8'h20) && (char_in <= 8'h7E);

  always_comb begin
    we      = 1'b0;
    wr_addr = row_base + ADDR_W'(col_q);
    wr_data = char_in;
    case (state_q)
      CLEAR_ALL: begin
        we      = 1'b1;
        wr_addr = clr_cnt_q;
        wr_data = BLANK;
      end
      CLEAR_ROW: begin
        we      = 1'b1;
        wr_addr = row_base + clr_cnt_q;
        wr_data = BLANK;
      end
      IDLE:    we = accept && printable;
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Non-blocking read of the same array gives read-first behaviour on a collision.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) code_q <= BLANK;
    else             code_q <= in_range ? mem[rd_addr] : BLANK;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= CLEAR_ALL;
      clr_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR_ALL: begin
          if (clr_cnt_q == LAST_CELL) begin
            clr_cnt_q <= '0;
            state_q   <= IDLE;
            ready_q   <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        CLEAR_ROW: begin
          if (clr_cnt_q == LAST_ROW_CELL) begin
            clr_cnt_q <= '0;
            state_q   <= IDLE;
            ready_q   <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        IDLE: begin
          clr_cnt_q <= '0;
          if (accept) begin
            if (printable) begin
              if (col_q == LAST_COL) begin
                col_q   <= '0;
                row_q   <= next_row;
                state_q <= CLEAR_ROW;
                ready_q <= 1'b0;
              end else begin
                col_q <= col_q + 7'd1;
              end
            end else begin
              case (char_in)
                8'h0A: begin
                  col_q   <= '0;
                  row_q   <= next_row;
                  state_q <= CLEAR_ROW;
                  ready_q <= 1'b0;
                end
                8'h0D: col_q <= '0;
                8'h08: if (col_q != 7'd0) col_q <= col_q - 7'd1;
                8'h0C: begin
                  col_q   <= '0;
                  row_q   <= '0;
                  state_q <= CLEAR_ALL;
                  ready_q <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          state_q   <= CLEAR_ALL;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out      = ready_q;
  assign char_code_out  = code_q;
  assign cursor_col_out = col_q;
  assign cursor_row_out = row_q;
  assign dbg_state_out  = state_q;

endmodule
